// File: rtl/dino_pkg.sv
// Shared constants and types for the dino sprite renderer.
// Frame bases select between the two run-animation sprite images in the ROM.
package dino_pkg;

    localparam int SPR_W    = 22;
    localparam int SPR_H    = 47;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [11:0] FRAME_BASE_0 = 12'h000;
    localparam logic [11:0] FRAME_BASE_1 = 12'h100;

    // Per-pixel side-band that travels with the ROM access.
    typedef struct packed {
        logic       hit;
        logic       valid;
        logic [4:0] col;
    } pix_stage_t;

    function automatic logic [11:0] frame_base(input logic frame_sel);
        return frame_sel ? FRAME_BASE_1 : FRAME_BASE_0;
    endfunction

endpackage

// File: rtl/dino_anim_ctrl.sv
// Frame-rate control for the dino: latches the sprite position once per frame
// and advances the two-frame run animation every ANIM_DIV frame ticks.
module dino_anim_ctrl
    import dino_pkg::*;
#(
    parameter int ANIM_DIV = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] dino_x,
    input  logic [9:0] dino_y,
    input  logic       running,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       frame_sel
);

    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    logic [7:0] anim_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= '0;
            pos_y     <= '0;
            frame_sel <= 1'b0;
            anim_cnt  <= '0;
        end else if (frame_tick) begin
            pos_x <= dino_x;
            pos_y <= dino_y;
            if (running) begin
                if (anim_cnt == ANIM_LAST) begin
                    anim_cnt  <= '0;
                    frame_sel <= ~frame_sel;
                end else begin
                    anim_cnt <= anim_cnt + 8'd1;
                end
            end else begin
                // Standing still always shows the first frame and restarts the cadence.
                anim_cnt  <= '0;
                frame_sel <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dino_sprite_render.sv
// Three-stage pixel pipeline: position compare and ROM address, ROM read,
// then column select into a single dino pixel aligned with a delayed valid.
module dino_sprite_render
    import dino_pkg::*;
#(
    parameter int SPR_W      = dino_pkg::SPR_W,
    parameter int SPR_H      = dino_pkg::SPR_H,
    parameter int SCALE_LOG2 = 0,
    parameter int ANIM_DIV   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic             pix_valid,
    input  logic             frame_tick,
    input  logic [9:0]       dino_x,
    input  logic [9:0]       dino_y,
    input  logic             running,
    output logic [11:0]      addr_dino,
    input  logic [SPR_W-1:0] outd,
    output logic             dino_pix,
    output logic             dino_valid
);

    localparam logic [10:0] W_LIM = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] H_LIM = 11'(SPR_H << SCALE_LOG2);

    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        frame_sel;

    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit;
    logic [5:0]  row;
    logic [4:0]  col;

    pix_stage_t  st1;
    pix_stage_t  st2;

    dino_anim_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .dino_x     (dino_x),
        .dino_y     (dino_y),
        .running    (running),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .frame_sel  (frame_sel)
    );

    // 11-bit difference keeps the sign so scan positions left/above the sprite never alias.
    assign dx  = {1'b0, pix_x} - {1'b0, pos_x};
    assign dy  = {1'b0, pix_y} - {1'b0, pos_y};
    assign hit = pix_valid & ~dx[10] & (dx < W_LIM) & ~dy[10] & (dy < H_LIM);
    assign row = 6'(dy >> SCALE_LOG2);
    assign col = 5'(dx >> SCALE_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_dino <= '0;
            st1       <= '0;
        end else begin
            if (hit) begin
                addr_dino <= frame_base(frame_sel) | {6'b000000, row};
            end
            st1.hit   <= hit;
            st1.valid <= pix_valid;
            st1.col   <= hit ? col : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st2 <= '0;
        end else begin
            st2 <= st1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_pix   <= 1'b0;
            dino_valid <= 1'b0;
        end else begin
            dino_pix   <= st2.hit & outd[st2.col];
            dino_valid <= st2.valid;
        end
    end

endmodule

// File: tb/tb_dino_sprite_render.sv
// Scoreboard bench for dino_sprite_render at SCALE_LOG2 = 0 and 1 side by side,
// against a behavioural sprite model and a registered ROM model.
module tb_dino_sprite_render;

    localparam int ANIM_DIV = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_valid = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  dino_x = '0;
    logic [9:0]  dino_y = '0;
    logic        running = 1'b0;

    logic [11:0] addr_dino0, addr_dino1;
    logic [21:0] outd0 = '0, outd1 = '0;
    logic        dino_pix0, dino_pix1;
    logic        dino_valid0, dino_valid1;

    logic [21:0] rom [0:4095];

    typedef struct {
        bit pix;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int m_pos_x = 0, m_pos_y = 0, m_frame = 0, m_run_ticks = 0;
    int exp_addr0 = 0, exp_addr1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        outd0 <= rom[addr_dino0];
        outd1 <= rom[addr_dino1];
    end

    dino_sprite_render #(.SCALE_LOG2(0), .ANIM_DIV(ANIM_DIV)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_tick(frame_tick), .dino_x(dino_x), .dino_y(dino_y), .running(running),
        .addr_dino(addr_dino0), .outd(outd0), .dino_pix(dino_pix0), .dino_valid(dino_valid0)
    );

    dino_sprite_render #(.SCALE_LOG2(1), .ANIM_DIV(ANIM_DIV)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_tick(frame_tick), .dino_x(dino_x), .dino_y(dino_y), .running(running),
        .addr_dino(addr_dino1), .outd(outd1), .dino_pix(dino_pix1), .dino_valid(dino_valid1)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Sprite model: which ROM word and bit a screen pixel lands on, from plain geometry.
    task automatic model_pix(input int sc, input int px, input int py, input bit pv,
                             output bit hit, output int addr, output bit pix);
        int dx;
        int dy;
        dx   = px - m_pos_x;
        dy   = py - m_pos_y;
        hit  = pv && dx >= 0 && dx < (22 << sc) && dy >= 0 && dy < (47 << sc);
        addr = hit ? (m_frame * 256 + (dy >> sc)) : 0;
        pix  = hit ? rom[addr][dx >> sc] : 1'b0;
    endtask

    task automatic step(input int px, input int py, input bit pv, input bit tick,
                        input int nx, input int ny, input bit run);
        bit   h0, h1;
        int   a0, a1;
        bit   p0, p1;
        exp_t e;
        @(negedge clk);
        check("addr_s0", addr_dino0, exp_addr0);
        check("addr_s1", addr_dino1, exp_addr1);
        pix_x      = px[9:0];
        pix_y      = py[9:0];
        pix_valid  = pv;
        frame_tick = tick;
        dino_x     = nx[9:0];
        dino_y     = ny[9:0];
        running    = run;
        model_pix(0, px & 1023, py & 1023, pv, h0, a0, p0);
        model_pix(1, px & 1023, py & 1023, pv, h1, a1, p1);
        if (pv) begin
            e.due = cyc + 3;
            e.pix = p0;
            q0.push_back(e);
            e.pix = p1;
            q1.push_back(e);
        end
        if (h0) exp_addr0 = a0;
        if (h1) exp_addr1 = a1;
        if (tick) begin
            m_pos_x = nx & 1023;
            m_pos_y = ny & 1023;
            if (run) begin
                m_run_ticks++;
                m_frame = (m_run_ticks / ANIM_DIV) % 2;
            end else begin
                m_run_ticks = 0;
                m_frame     = 0;
            end
        end
    endtask

    task automatic tick(input int nx, input int ny, input bit run);
        step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b1, nx, ny, run);
    endtask

    task automatic scan_row(input int py, input int x0, input int x1);
        for (int x = x0; x <= x1; x++)
            step(x, py, 1'b1, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), running);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pix", dino_pix0, 0);
        check("rst_valid", dino_valid0, 0);
        check("rst_addr", addr_dino0, 0);
        check("rst_addr_s1", addr_dino1, 0);
        q0.delete();
        q1.delete();
        m_pos_x = 0; m_pos_y = 0; m_frame = 0; m_run_ticks = 0;
        exp_addr0 = 0; exp_addr1 = 0;
        repeat (3) @(negedge clk);
        pix_valid  = 1'b0;
        frame_tick = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_pix0", dino_pix0, 0);
            check("reset_valid0", dino_valid0, 0);
            check("reset_addr0", addr_dino0, 0);
            check("reset_valid1", dino_valid1, 0);
        end else if (dino_valid0) begin
            if (q0.size() == 0) begin
                check("unexpected_valid0", 1, 0);
            end else begin
                e = q0.pop_front();
                check("pix_s0", dino_pix0, e.pix);
                check("latency_s0", cyc, e.due);
            end
        end else begin
            check("idle_pix0", dino_pix0, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dino_valid1) begin
                if (q1.size() == 0) begin
                    check("unexpected_valid1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("pix_s1", dino_pix1, e.pix);
                    check("latency_s1", cyc, e.due);
                end
            end else begin
                check("idle_pix1", dino_pix1, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nx, ny;
        for (int i = 0; i < 4096; i++) rom[i] = 22'($urandom);

        // Reset held while the scan is live.
        pix_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            pix_x = 10'($urandom);
            pix_y = 10'($urandom);
        end
        pix_valid = 1'b0;
        #2 rst_n = 1'b1;

        // Row/column mapping and right-edge end of sprite.
        tick(100, 200, 1'b0);
        scan_row(202, 95, 125);

        // Left of and above the sprite.
        step(99, 200, 1'b1, 1'b0, 0, 0, 1'b0);
        step(100, 199, 1'b1, 1'b0, 0, 0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Animation cadence, hold on stop and restart from zero.
        repeat (6) tick(100, 200, 1'b1);
        scan_row(205, 98, 124);
        repeat (6) tick(100, 200, 1'b1);
        scan_row(205, 98, 124);
        repeat (3) tick(100, 200, 1'b1);
        tick(100, 200, 1'b0);
        repeat (5) tick(100, 200, 1'b1);
        scan_row(205, 98, 124);
        tick(100, 200, 1'b1);
        scan_row(205, 98, 124);

        // Tick coincident with a live pixel: that pixel still uses the old position.
        step(105, 205, 1'b1, 1'b1, 104, 203, 1'b1);
        scan_row(205, 100, 127);

        // Clipping at the bottom-right of the active area.
        tick(630, 470, 1'b0);
        foreach (q0[i]) ;
        scan_row(469, 620, 639);
        scan_row(470, 620, 639);
        scan_row(474, 625, 639);
        scan_row(479, 620, 639);

        // Sprite parked off-screen.
        tick(700, 10, 1'b0);
        scan_row(10, 600, 639);

        // Upscaled geometry, and the 1x instance sees the same scan.
        tick(0, 0, 1'b0);
        scan_row(3, 0, 50);
        scan_row(93, 30, 50);
        scan_row(94, 30, 50);
        scan_row(0, 0, 25);

        // Reset in the middle of a line.
        tick(100, 200, 1'b1);
        scan_row(201, 100, 110);
        reset_pulse();
        scan_row(1, 0, 30);

        // Randomized traffic around the sprite with random ticks.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                nx = $urandom_range(0, 700);
                ny = $urandom_range(0, 520);
                step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                     1'b1, nx, ny, ($urandom_range(0, 3) != 0));
            end else begin
                step((m_pos_x + $urandom_range(0, 110) - 10) & 1023,
                     (m_pos_y + $urandom_range(0, 110) - 10) & 1023,
                     ($urandom_range(0, 3) != 0), 1'b0,
                     $urandom_range(0, 1023), $urandom_range(0, 1023), running);
            end
        end

        repeat (6) step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("drain_s0", q0.size(), 0);
        check("drain_s1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
